// File: rtl/note_player_pkg.sv
// Shared constants for the note player: FSM encodings, tick sizing and
// 50 MHz half-period values for melody sources.
package note_player_pkg;
    localparam int DEF_DIV_W = 17;
    localparam int DEF_LEN_W = 6;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_PLAY = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    // clk cycles per duration tick, never below one
    function automatic int tick_cyc(input int clk_hz, input int tick_hz);
        return (clk_hz / tick_hz < 1) ? 1 : clk_hz / tick_hz;
    endfunction

    localparam logic [DEF_DIV_W-1:0] NOTE_C4 = 17'd95556;
    localparam logic [DEF_DIV_W-1:0] NOTE_D4 = 17'd85131;
    localparam logic [DEF_DIV_W-1:0] NOTE_E4 = 17'd75843;
    localparam logic [DEF_DIV_W-1:0] NOTE_F4 = 17'd71586;
    localparam logic [DEF_DIV_W-1:0] NOTE_G4 = 17'd63776;
    localparam logic [DEF_DIV_W-1:0] NOTE_A4 = 17'd56818;
    localparam logic [DEF_DIV_W-1:0] NOTE_B4 = 17'd50619;
    localparam logic [DEF_DIV_W-1:0] NOTE_C5 = 17'd47778;
    localparam logic [DEF_DIV_W-1:0] NOTE_D5 = 17'd42566;
    localparam logic [DEF_DIV_W-1:0] NOTE_E5 = 17'd37921;
    localparam logic [DEF_DIV_W-1:0] NOTE_F5 = 17'd35793;
    localparam logic [DEF_DIV_W-1:0] NOTE_G5 = 17'd31888;
    localparam logic [DEF_DIV_W-1:0] NOTE_A5 = 17'd28409;
    localparam logic [DEF_DIV_W-1:0] NOTE_B5 = 17'd25310;
    localparam logic [DEF_DIV_W-1:0] NOTE_C6 = 17'd23889;
    localparam logic [DEF_DIV_W-1:0] NOTE_REST = 17'd0;
endpackage

// File: rtl/note_player_tone_div.sv
// Half-period counter and toggle flop producing the square wave.
// div == 0 freezes the counter so the output stays low (rest).
module tone_div #(
    parameter int DIV_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             wave
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             wave_q, wave_d;

    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (clr) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (en && div != '0) begin
            if (cnt_q == div - 1'b1) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;
endmodule

// File: rtl/note_player.sv
// Note sequencer: accepts (half-period, duration) notes, plays each as a
// square wave on bz1 for len ticks, then inserts a silent gap.
module note_player
    import note_player_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 16,
    parameter int GAP_TICKS = 1,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [DIV_W-1:0] note_div,
    input  logic [LEN_W-1:0] note_len,
    output logic             bz1,
    output logic             busy
);
    localparam int TICK_CYC = tick_cyc(CLK_HZ, TICK_HZ);
    localparam int TW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_CYC - 1);
    localparam logic [LEN_W-1:0] GAP_LAST  = LEN_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [LEN_W-1:0] lcnt_q, lcnt_d;
    logic             tick_wrap, play_last, gap_last;

    assign tick_wrap = (tick_q == TICK_LAST);
    assign play_last = (state_q == ST_PLAY) && tick_wrap && (lcnt_q == len_q - 1'b1);
    assign gap_last  = (state_q == ST_GAP) && tick_wrap && (lcnt_q == GAP_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        len_d   = len_q;
        tick_d  = tick_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (note_valid) begin
                    div_d  = note_div;
                    len_d  = note_len;
                    tick_d = '0;
                    lcnt_d = '0;
                    if (note_len != '0) state_d = ST_PLAY;
                end
            end
            ST_PLAY, ST_GAP: begin
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                if (tick_wrap) lcnt_d = lcnt_q + 1'b1;
                // both phases share the tick/len counters, so clear on exit
                if (play_last) begin
                    tick_d  = '0;
                    lcnt_d  = '0;
                    state_d = (GAP_TICKS > 0) ? ST_GAP : ST_IDLE;
                end else if (gap_last) begin
                    tick_d  = '0;
                    lcnt_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            len_q   <= '0;
            tick_q  <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            len_q   <= len_d;
            tick_q  <= tick_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // tone is held cleared outside PLAY and forced low after the last PLAY cycle
    tone_div #(.DIV_W(DIV_W)) u_tone (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_PLAY),
        .clr  ((state_q != ST_PLAY) || play_last),
        .div  (div_q),
        .wave (bz1)
    );

    assign busy       = (state_q != ST_IDLE);
    assign note_ready = (state_q == ST_IDLE);
endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: per-cycle expected {bz1,busy,ready}
// is queued as each note is driven and compared at the falling edge.
module tb_note_player;
    localparam int TC  = 10;
    localparam int GAP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        note_valid;
    logic        note_ready;
    logic [16:0] note_div;
    logic [5:0]  note_len;
    logic        bz1;
    logic        busy;

    typedef struct {
        logic [2:0] v;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   busy_cnt = 0;
    bit   busy_en  = 1'b0;

    note_player #(
        .CLK_HZ(1000), .TICK_HZ(100), .GAP_TICKS(GAP), .DIV_W(17), .LEN_W(6)
    ) dut (
        .clk(clk), .rst(rst), .note_valid(note_valid), .note_ready(note_ready),
        .note_div(note_div), .note_len(note_len), .bz1(bz1), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy_en && busy) busy_cnt <= busy_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic push(input logic [2:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        q.push_back(e);
    endtask

    // sample the current cycle, then step past the next rising edge
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, {29'd0, bz1, busy, note_ready}, {29'd0, e.v});
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic tone_exp(input int d, input int k);
        if (d == 0) return 1'b0;
        return ((k - 1) / d) % 2 == 1;
    endfunction

    task automatic note(input logic [16:0] d, input logic [5:0] l, input bit hold);
        note_valid = 1'b1;
        note_div   = d;
        note_len   = l;
        push(3'b001, "accept");
        cyc();
        note_valid = hold;
        for (int k = 1; k <= int'(l) * TC; k++) begin
            push({tone_exp(int'(d), k), 2'b10}, "play");
            if (hold) begin
                note_div = 17'($urandom);
                note_len = 6'($urandom_range(1, 63));
            end
            cyc();
        end
        if (l != 0) begin
            for (int g = 0; g < GAP * TC; g++) begin
                push(3'b010, "gap");
                cyc();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] divs [4];
        divs[0] = 17'd3; divs[1] = 17'd1; divs[2] = 17'd0; divs[3] = 17'd4;

        rst = 1'b1; note_valid = 1'b0; note_div = '0; note_len = '0;
        #1;
        chk("rst_bz1", {31'd0, bz1}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, note_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        note(17'd3, 6'd2, 1'b0);
        note(17'd0, 6'd1, 1'b0);
        note(17'd5, 6'd0, 1'b0);
        note(17'd1, 6'd1, 1'b0);

        busy_en = 1'b1;
        for (int i = 0; i < 4; i++) note(divs[i], 6'd2, i != 3);
        note_valid = 1'b0;
        busy_en = 1'b0;
        chk("b2b_busy_cycles", busy_cnt, 4 * 2 * TC + 4 * GAP * TC);

        note_valid = 1'b1; note_div = 17'd2; note_len = 6'd3;
        push(3'b001, "mid_accept");
        cyc();
        note_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            push({tone_exp(2, k), 2'b10}, "mid_play");
            cyc();
        end
        chk("mid_bz1_pre", {31'd0, bz1}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_bz1", {31'd0, bz1}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, note_ready}, 32'd1);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        note(17'd2, 6'd1, 1'b0);

        repeat (3) begin
            push(3'b001, "idle_tail");
            cyc();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
